// File: rtl/bootloader.sv
// Bootloader: streams a RAM_DEPTH-byte program image from a byte source into CPU RAM
// by requesting MAR-load and RAM-write cycles from the control unit, one byte at a time.
module bootloader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  boot_write_to_bus,
  output logic                  bootload_address,
  output logic                  bootload_ram,
  output logic [DATA_WIDTH-1:0] boot_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  byte_q, byte_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    byte_d           = byte_q;
    byte_ready       = 1'b0;
    bootload_address = 1'b0;
    bootload_ram     = 1'b0;
    boot_data        = '0;
    busy             = 1'b0;
    done             = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RECV;
          addr_d  = '0;
        end
      end

      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          byte_d  = byte_in;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        bootload_address = 1'b1;
        boot_data        = DATA_WIDTH'(addr_q);
        busy             = 1'b1;
        if (boot_write_to_bus) state_d = S_DATA;
      end

      S_DATA: begin
        bootload_ram = 1'b1;
        boot_data    = byte_q;
        busy         = 1'b1;
        if (boot_write_to_bus) begin
          // Terminate on the last address rather than letting the counter wrap.
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_RECV;
          end
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = S_RECV;
          addr_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bootloader.sv
// Directed bench for bootloader: reset behaviour, full loads with ack delays,
// source gaps, ignored start/ack pulses and a mid-load reset with restart.
module tb_bootloader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       boot_write_to_bus;
  logic       bootload_address;
  logic       bootload_ram;
  logic [7:0] boot_data;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  bootloader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .boot_write_to_bus(boot_write_to_bus),
    .bootload_address (bootload_address),
    .bootload_ram     (bootload_ram),
    .boot_data        (boot_data),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] outs();
    return {byte_ready, bootload_address, bootload_ram, busy, done, boot_data};
  endfunction

  // Runs one load from a start pulse. Optional disturbances (-1 disables):
  //   hold_addr  : withhold the ADDR ack 3 cycles for this address
  //   gap_byte   : drop byte_valid 5 RECV cycles before this byte index
  //   start_addr : pulse start during the DATA cycle of this address
  //   ackr_byte  : pulse boot_write_to_bus in RECV before this byte index
  //   rst_addr   : assert rst in the ADDR cycle of this address and stop
  task automatic do_load(input string name, input logic [7:0] base,
                         input int hold_addr, input int gap_byte,
                         input int start_addr, input int ackr_byte,
                         input int rst_addr, input int exp_cycles,
                         input int exp_addr_cycles);
    int cyc = 0, k = 0, n_addr = 0, n_data = 0, gap = 0, hold = 0, addr_cyc = 0;
    logic prev_aack = 1'b0;
    start = 1'b1; byte_valid = 1'b1; byte_in = base; boot_write_to_bus = 1'b0;
    step();
    start = 1'b0;
    check({name, ":first_recv"}, {busy, byte_ready, done, bootload_address, bootload_ram}, 5'b11000);
    while (cyc < 200) begin
      start = 1'b0; boot_write_to_bus = 1'b0; byte_valid = 1'b1; byte_in = base + 8'(k);
      check({name, ":mutex"}, {31'd0, bootload_address & bootload_ram}, 0);
      check({name, ":busy"}, {busy, done}, 2'b10);
      if (bootload_address && n_addr == rst_addr) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check({name, ":rst_outs"}, outs(), 0);
        return;
      end
      if (byte_ready) begin
        check({name, ":rdy_quiet"}, {bootload_address, bootload_ram}, 0);
        if (k == ackr_byte) boot_write_to_bus = 1'b1;
        if (k == gap_byte && gap < 5) begin
          byte_valid = 1'b0;
          gap++;
        end else begin
          k++;
        end
      end
      check({name, ":ram_after_ack"}, bootload_ram, prev_aack);
      prev_aack = 1'b0;
      if (bootload_address) begin
        addr_cyc++;
        check({name, ":addr_val"}, boot_data, n_addr);
        if (n_addr == hold_addr && hold < 3) begin
          hold++;
        end else begin
          boot_write_to_bus = 1'b1;
          prev_aack = 1'b1;
          n_addr++;
        end
      end
      if (bootload_ram) begin
        check({name, ":data_val"}, boot_data, base + 8'(n_data));
        check({name, ":data_order"}, n_data + 1, n_addr);
        boot_write_to_bus = 1'b1;
        if (n_data == start_addr) start = 1'b1;
        n_data++;
      end
      step();
      cyc++;
      if (done) break;
    end
    boot_write_to_bus = 1'b0;
    start = 1'b0;
    check({name, ":cycles"}, cyc, exp_cycles);
    check({name, ":done_state"}, {busy, done, byte_ready, bootload_address, bootload_ram}, 5'b01000);
    check({name, ":done_data"}, boot_data, 0);
    check({name, ":n_addr"}, n_addr, 16);
    check({name, ":n_data"}, n_data, 16);
    check({name, ":addr_cycles"}, addr_cyc, exp_addr_cycles);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5; boot_write_to_bus = 1'b1;
    step();
    step();
    check("reset_outs", outs(), 0);
    rst = 1'b0; start = 1'b0; boot_write_to_bus = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_quiet", outs(), 0);
    end

    do_load("zero_wait", 8'h10, -1, -1, -1, -1, -1, 48, 16);
    for (int i = 0; i < 3; i++) begin
      step();
      check("done_hold", {busy, done}, 2'b01);
    end

    do_load("ack_delay", 8'h20, 5, -1, -1, -1, -1, 51, 19);
    do_load("src_gap", 8'h30, -1, 3, -1, -1, -1, 53, 16);
    do_load("ignored", 8'h40, -1, -1, 7, 4, -1, 48, 16);
    do_load("rst_mid", 8'h50, -1, -1, -1, -1, 9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_idle", outs(), 0);
    end
    do_load("restart", 8'h60, -1, -1, -1, -1, -1, 48, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bootloader.md
Name: bootloader

Overview:
- Feeds a program image into the CPU's 16-byte RAM before execution.
- Sits between a byte source (serial receiver or switch-panel front end) and the control unit. It drives the control unit's bootload_address and bootload_ram request inputs.
- It supplies the byte the control unit places on the bus whenever the control unit asserts boot_write_to_bus.
- It is the requesting end of the bootload interface the control unit responds to.

Parameters:
- DATA_WIDTH, 8, bus and byte width.
- ADDR_WIDTH, 4, RAM address width.
- RAM_DEPTH, 16, number of bytes loaded per boot; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a boot load.
- byte_in  input  DATA_WIDTH  next program byte from the source.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  bootloader can accept a byte.
- boot_write_to_bus  input  1  ack from control: boot_data is on the bus this cycle.
- bootload_address  output  1  request a MAR-load cycle from control.
- bootload_ram  output  1  request a RAM-write cycle from control.
- boot_data  output  DATA_WIDTH  value to drive on the bus.
- busy  output  1  load in progress; control keeps the CPU halted.
- done  output  1  full image loaded.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset values: state IDLE, addr counter 0, byte register 0. All outputs 0: byte_ready, bootload_address, bootload_ram, boot_data, busy, done.
- States and transitions:
  - IDLE: all outputs 0. start=1 -> RECV, addr cleared to 0.
  - RECV: byte_ready=1, busy=1. byte_valid&byte_ready captures byte_in into the byte register -> ADDR next cycle. byte_ready drops in ADDR.
  - ADDR: bootload_address=1, boot_data={zeros, addr}, busy=1. Request is held with stable boot_data until boot_write_to_bus=1. On the ack cycle -> DATA. The request deasserts the next cycle, so it is exactly one acked cycle.
  - DATA: bootload_ram=1, boot_data=byte register, busy=1. On ack:
    - addr==RAM_DEPTH-1 -> DONE.
    - otherwise addr+1 -> RECV.
  - DONE: done=1, busy=0, boot_data=0. done stays high until rst or a new start. start in DONE -> RECV, addr=0, done drops next cycle.
- bootload_address and bootload_ram are never high together. Neither is high outside ADDR/DATA.
- boot_write_to_bus while in IDLE/RECV/DONE is ignored.
- start while busy is ignored; addr and byte are unaffected.
- byte_valid while not in RECV is ignored (no capture, byte_ready=0).
- Minimum per-byte time: 3 cycles (RECV accept, ADDR ack, DATA ack), giving a 16-byte load in 48 cycles with zero-wait source and control.
- Address counter is ADDR_WIDTH bits. It never wraps during a load; termination is on the last address.
- rst mid-load (any state) -> IDLE next edge, all outputs 0 from that edge. A partially written RAM is not rolled back.
- Simultaneous start and rst: rst wins.

Test Plan:
- Reset: hold rst 2 cycles with start=1, byte_valid=1 -> every output 0, state IDLE; after release, no activity without a new start pulse.
- Full load, zero-wait: start pulse, then bytes 0x10..0x1F presented continuously, boot_write_to_bus tied to (bootload_address|bootload_ram):
  - 16 ADDR cycles with boot_data 0x00..0x0F.
  - 16 DATA cycles with 0x10..0x1F.
  - done=1 exactly 48 cycles after the first RECV cycle; busy=0 then.
- Delayed ack: ack withheld 3 cycles in ADDR for addr 5 -> bootload_address and boot_data=0x05 held stable 4 cycles; bootload_ram rises only the cycle after ack.
- Source gaps: byte_valid low 5 cycles before byte 3 -> byte_ready=1 throughout, no requests issued; the load completes with correct data order.
- Ignored events: start pulsed during DATA for addr 7, and boot_write_to_bus pulsed in RECV -> no restart, no address skip; addr 7 written with its byte.
- Reset mid-load then restart: rst during ADDR for addr 9 -> IDLE, outputs 0. A new start reloads from addr 0, and done asserts only after address 0x0F.
